regread: RTL and testbench

- Register-read (RR) stage of the 16-bit, 8-register pipeline, sitting between decode and execute.
- Holds the architectural register file, written by the WB stage.
- Reads operands A/B with EX > MEM > WB forwarding, detects load-use hazards, squashes wrong-path instructions after a taken branch, and registers everything into the RR/EX pipeline register.

---
 rtl/def_ex_pkg.sv | 32 +++
 rtl/rr_fwd_mux.sv | 35 +++
 rtl/regread.sv | 160 ++++++++++++++++
 tb/tb_regread.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/def_ex_pkg.sv
// Shared definitions for the execute-side pipeline stages.
// Holds datapath widths, one-hot opcode bit positions and the register-read
// squash state encoding.
package def_ex;

  localparam int unsigned DW   = 16;  // data / PC / instruction width
  localparam int unsigned NREG = 8;   // general-purpose registers
  localparam int unsigned RIW  = 3;   // register index width
  localparam int unsigned OHW  = 26;  // one-hot opcode width

  // One-hot opcode bit positions
  localparam int unsigned ADD = 0;
  localparam int unsigned ADC = 1;
  localparam int unsigned ADZ = 2;
  localparam int unsigned ADI = 3;
  localparam int unsigned NDU = 4;
  localparam int unsigned NDC = 5;
  localparam int unsigned NDZ = 6;
  localparam int unsigned LHI = 7;
  localparam int unsigned LW  = 8;
  localparam int unsigned SW  = 9;
  localparam int unsigned LM  = 10;
  localparam int unsigned SM  = 11;
  localparam int unsigned BEQ = 12;
  localparam int unsigned JAL = 13;
  localparam int unsigned JLR = 14;

  // Squash state encoding
  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StSquash = 1'b1;

endpackage

// File: rtl/rr_fwd_mux.sv
// Operand select for one source register.
// Priority: r0 -> 0, then EX, MEM, WB forwarding, then the register file.
//   idx_i        source register index
//   *_rd_idx_i   destination index of each later stage
//   *_val_i      result value of each later stage
//   rf_val_i     register-file read of idx_i
//   operand_o    selected operand
module rr_fwd_mux
  import def_ex::*;
(
  input  logic [RIW-1:0] idx_i,
  input  logic [RIW-1:0] ex_rd_idx_i,
  input  logic [DW-1:0]  ex_val_i,
  input  logic [RIW-1:0] mem_rd_idx_i,
  input  logic [DW-1:0]  mem_val_i,
  input  logic [RIW-1:0] wb_rd_idx_i,
  input  logic [DW-1:0]  wb_val_i,
  input  logic [DW-1:0]  rf_val_i,
  output logic [DW-1:0]  operand_o
);

  always_comb begin
    operand_o = rf_val_i;
    if (idx_i == '0) begin
      operand_o = '0;
    end else if (idx_i == ex_rd_idx_i) begin
      operand_o = ex_val_i;
    end else if (idx_i == mem_rd_idx_i) begin
      operand_o = mem_val_i;
    end else if (idx_i == wb_rd_idx_i) begin
      operand_o = wb_val_i;
    end
  end

endmodule

// File: rtl/regread.sv
// Register-read stage: register file, operand forwarding, load-use stall,
// wrong-path squash after a taken branch, and the RR/EX pipeline register.
//   clk_i, rst_i          clock, asynchronous active-low reset
//   opcode_*_i, one_hot_i, imm_val_i, dec_*_idx_i   decode slot
//   load_en_i             instruction in EX is a load
//   branch_*_i            redirect from a later stage
//   ex/mem/wb_*_i         later-stage results for forwarding; WB writes the file
//   *_o, operand_val_a/b  RR/EX pipeline register
//   mem_stall_o           combinational load-use stall request
module regread
  import def_ex::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           opcode_valid_i,
  input  logic [DW-1:0]  opcode_pc_i,
  input  logic [DW-1:0]  opcode_instr_i,
  input  logic [OHW-1:0] one_hot_i,
  input  logic [DW-1:0]  imm_val_i,
  input  logic           load_en_i,
  input  logic [RIW-1:0] dec_rd_idx_i,
  input  logic [RIW-1:0] dec_ra_idx_i,
  input  logic [RIW-1:0] dec_rb_idx_i,
  input  logic           branch_valid_i,
  input  logic [1:0]     branch_type_i,
  input  logic [DW-1:0]  branch_pc_i,
  input  logic [DW-1:0]  ex_val_i,
  input  logic [RIW-1:0] ex_rd_idx_i,
  input  logic [DW-1:0]  mem_val_i,
  input  logic [RIW-1:0] mem_rd_idx_i,
  input  logic [DW-1:0]  wb_val_i,
  input  logic [RIW-1:0] wb_rd_idx_i,
  output logic           opcode_valid_o,
  output logic [DW-1:0]  opcode_pc_o,
  output logic [DW-1:0]  opcode_instr_o,
  output logic [OHW-1:0] one_hot_o,
  output logic [DW-1:0]  operand_val_a,
  output logic [DW-1:0]  operand_val_b,
  output logic [RIW-1:0] exec_rd_idx_o,
  output logic [DW-1:0]  imm_val_o,
  output logic           mem_stall_o
);

  // Branch kind is reserved for future use
  logic unused_branch_type;
  assign unused_branch_type = ^branch_type_i;

  // Register file; entry 0 is never written so it stays 0 after reset
  logic [DW-1:0] gpr [0:NREG-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wb_rd_idx_i != '0) begin
      gpr[wb_rd_idx_i] <= wb_val_i;
    end
  end

  logic [DW-1:0] opnd_a, opnd_b;

  rr_fwd_mux u_fwd_a (
    .idx_i       (dec_ra_idx_i),
    .ex_rd_idx_i (ex_rd_idx_i),
    .ex_val_i    (ex_val_i),
    .mem_rd_idx_i(mem_rd_idx_i),
    .mem_val_i   (mem_val_i),
    .wb_rd_idx_i (wb_rd_idx_i),
    .wb_val_i    (wb_val_i),
    .rf_val_i    (gpr[dec_ra_idx_i]),
    .operand_o   (opnd_a)
  );

  rr_fwd_mux u_fwd_b (
    .idx_i       (dec_rb_idx_i),
    .ex_rd_idx_i (ex_rd_idx_i),
    .ex_val_i    (ex_val_i),
    .mem_rd_idx_i(mem_rd_idx_i),
    .mem_val_i   (mem_val_i),
    .wb_rd_idx_i (wb_rd_idx_i),
    .wb_val_i    (wb_val_i),
    .rf_val_i    (gpr[dec_rb_idx_i]),
    .operand_o   (opnd_b)
  );

  // Both sources compared regardless of opcode: conservative but safe
  assign mem_stall_o = opcode_valid_i & load_en_i & (ex_rd_idx_i != '0) &
                       ((dec_ra_idx_i == ex_rd_idx_i) | (dec_rb_idx_i == ex_rd_idx_i));

  // Squash FSM
  logic [0:0]    state_q, state_d;
  logic [DW-1:0] target_q, target_d;
  logic          pc_match, accept, load;

  assign pc_match = (opcode_pc_i == target_q);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (branch_valid_i) begin
      state_d  = StSquash;
      target_d = branch_pc_i;
    end else if (state_q == StSquash && opcode_valid_i && pc_match && !mem_stall_o) begin
      // Target reached and consumed; a stalled target stays pending until it moves on
      state_d = StIdle;
    end
  end

  assign accept = !branch_valid_i && (state_q == StIdle || pc_match);
  assign load   = accept && !mem_stall_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // RR/EX pipeline register; data fields hold while a bubble is issued
  logic           valid_q;
  logic [DW-1:0]  pc_q, instr_q, imm_q, opa_q, opb_q;
  logic [OHW-1:0] one_hot_q;
  logic [RIW-1:0] rd_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      one_hot_q <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
    end else begin
      valid_q <= load & opcode_valid_i;
      if (load) begin
        pc_q      <= opcode_pc_i;
        instr_q   <= opcode_instr_i;
        one_hot_q <= one_hot_i;
        opa_q     <= opnd_a;
        opb_q     <= opnd_b;
        rd_q      <= dec_rd_idx_i;
        imm_q     <= imm_val_i;
      end
    end
  end

  assign opcode_valid_o = valid_q;
  assign opcode_pc_o    = pc_q;
  assign opcode_instr_o = instr_q;
  assign one_hot_o      = one_hot_q;
  assign operand_val_a  = opa_q;
  assign operand_val_b  = opb_q;
  assign exec_rd_idx_o  = rd_q;
  assign imm_val_o      = imm_q;

endmodule

// File: tb/tb_regread.sv
module tb_regread;
  import def_ex::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           opcode_valid_i;
  logic [15:0]    opcode_pc_i, opcode_instr_i, imm_val_i, branch_pc_i;
  logic [25:0]    one_hot_i;
  logic           load_en_i, branch_valid_i;
  logic [2:0]     dec_rd_idx_i, dec_ra_idx_i, dec_rb_idx_i;
  logic [1:0]     branch_type_i;
  logic [15:0]    ex_val_i, mem_val_i, wb_val_i;
  logic [2:0]     ex_rd_idx_i, mem_rd_idx_i, wb_rd_idx_i;
  logic           opcode_valid_o, mem_stall_o;
  logic [15:0]    opcode_pc_o, opcode_instr_o, operand_val_a, operand_val_b, imm_val_o;
  logic [25:0]    one_hot_o;
  logic [2:0]     exec_rd_idx_o;

  regread dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .opcode_valid_i(opcode_valid_i), .opcode_pc_i(opcode_pc_i),
    .opcode_instr_i(opcode_instr_i), .one_hot_i(one_hot_i), .imm_val_i(imm_val_i),
    .load_en_i(load_en_i), .dec_rd_idx_i(dec_rd_idx_i), .dec_ra_idx_i(dec_ra_idx_i),
    .dec_rb_idx_i(dec_rb_idx_i), .branch_valid_i(branch_valid_i),
    .branch_type_i(branch_type_i), .branch_pc_i(branch_pc_i),
    .ex_val_i(ex_val_i), .ex_rd_idx_i(ex_rd_idx_i), .mem_val_i(mem_val_i),
    .mem_rd_idx_i(mem_rd_idx_i), .wb_val_i(wb_val_i), .wb_rd_idx_i(wb_rd_idx_i),
    .opcode_valid_o(opcode_valid_o), .opcode_pc_o(opcode_pc_o),
    .opcode_instr_o(opcode_instr_o), .one_hot_o(one_hot_o),
    .operand_val_a(operand_val_a), .operand_val_b(operand_val_b),
    .exec_rd_idx_o(exec_rd_idx_o), .imm_val_o(imm_val_o), .mem_stall_o(mem_stall_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural registers, pending redirect, expected slot
  logic [15:0] m_gpr [0:7];
  bit          m_waiting;
  logic [15:0] m_target;
  bit          e_valid;
  logic [15:0] e_pc, e_instr, e_imm, e_a, e_b;
  logic [25:0] e_oh;
  logic [2:0]  e_rd;

  function automatic logic [15:0] m_operand(input logic [2:0] idx);
    if (idx == 0)                 return 16'h0000;
    if (idx == ex_rd_idx_i)       return ex_val_i;
    if (idx == mem_rd_idx_i)      return mem_val_i;
    if (idx == wb_rd_idx_i)       return wb_val_i;
    return m_gpr[idx];
  endfunction

  function automatic bit m_stall();
    return opcode_valid_i && load_en_i && ex_rd_idx_i != 0 &&
           (dec_ra_idx_i == ex_rd_idx_i || dec_rb_idx_i == ex_rd_idx_i);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_gpr[i] = 16'h0;
    m_waiting = 0; m_target = 16'h0;
    e_valid = 0; e_pc = 0; e_instr = 0; e_imm = 0; e_a = 0; e_b = 0; e_oh = 0; e_rd = 0;
  endtask

  task automatic idle_inputs();
    opcode_valid_i = 0; opcode_pc_i = 0; opcode_instr_i = 0; one_hot_i = 0;
    imm_val_i = 0; load_en_i = 0; dec_rd_idx_i = 0; dec_ra_idx_i = 0; dec_rb_idx_i = 0;
    branch_valid_i = 0; branch_type_i = 0; branch_pc_i = 0;
    ex_val_i = 0; ex_rd_idx_i = 0; mem_val_i = 0; mem_rd_idx_i = 0;
    wb_val_i = 0; wb_rd_idx_i = 0;
  endtask

  task automatic set_instr(input int op, input logic [15:0] pc,
                           input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    opcode_valid_i = 1; opcode_pc_i = pc; one_hot_i = 26'd1 << op;
    opcode_instr_i = {pc[7:0], 5'(op), rd};
    imm_val_i = pc ^ 16'h5A5A;
    dec_rd_idx_i = rd; dec_ra_idx_i = ra; dec_rb_idx_i = rb;
  endtask

  // One clock: model consumes current inputs, DUT clocks, sample at edge + 1
  task automatic cycle();
    bit take;
    logic [15:0] a, b;
    a = m_operand(dec_ra_idx_i);
    b = m_operand(dec_rb_idx_i);
    take = !branch_valid_i && (!m_waiting || opcode_pc_i == m_target) && !m_stall();
    if (take) begin
      e_valid = opcode_valid_i; e_pc = opcode_pc_i; e_instr = opcode_instr_i;
      e_oh = one_hot_i; e_imm = imm_val_i; e_a = a; e_b = b; e_rd = dec_rd_idx_i;
    end else begin
      e_valid = 0;
    end
    if (branch_valid_i) begin
      m_waiting = 1; m_target = branch_pc_i;
    end else if (m_waiting && opcode_valid_i && opcode_pc_i == m_target && !m_stall()) begin
      m_waiting = 0;
    end
    if (wb_rd_idx_i != 0) m_gpr[wb_rd_idx_i] = wb_val_i;
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_gprs();
    logic [15:0] vals [1:7];
    vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444; vals[4] = 16'h5555;
    vals[5] = 16'h6666; vals[6] = 16'h7777; vals[7] = 16'h8888;
    for (int i = 1; i < 8; i++) begin
      idle_inputs();
      wb_rd_idx_i = 3'(i); wb_val_i = vals[i];
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 0;
    m_reset();
    #12;
    n_checks++;
    if ({opcode_valid_o, opcode_pc_o, opcode_instr_o, one_hot_o, operand_val_a,
         operand_val_b, exec_rd_idx_o, imm_val_o, mem_stall_o} !== '0)
      $display("FAIL reset_outputs: got valid=%0b pc=%h a=%h b=%h want all zero",
               opcode_valid_o, opcode_pc_o, operand_val_a, operand_val_b);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (dut.gpr[i] !== 16'h0) $display("FAIL reset_gpr%0d: got %h want 0000", i, dut.gpr[i]);
      else n_pass++;
    end
    @(negedge clk_i);
    rst_i = 1;
    #1;
  endtask

  task automatic test_wb_bypass();
    idle_inputs();
    set_instr(ADC, 16'h0102, 3'd4, 3'd5, 3'd1);
    wb_rd_idx_i = 5; wb_val_i = 16'h0014;
    cycle();
    n_checks++;
    if ({opcode_valid_o, operand_val_a, operand_val_b, exec_rd_idx_o} !==
        {1'b1, 16'h0014, 16'h2222, 3'd4})
      $display("FAIL wb_bypass: got v=%0b a=%h b=%h rd=%0d want 1 0014 2222 4",
               opcode_valid_o, operand_val_a, operand_val_b, exec_rd_idx_o);
    else n_pass++;
    n_checks++;
    if (opcode_pc_o !== 16'h0102 || one_hot_o !== (26'd1 << ADC))
      $display("FAIL wb_bypass_fields: got pc=%h oh=%h want 0102 %h",
               opcode_pc_o, one_hot_o, 26'd1 << ADC);
    else n_pass++;
    n_checks++;
    if (dut.gpr[5] !== 16'h0014) $display("FAIL wb_write: got %h want 0014", dut.gpr[5]);
    else n_pass++;
  endtask

  // Branch, one wrong-path slot, then the target; optional retarget mid-squash
  task automatic test_branch(input string nm, input logic [15:0] tgt, input bit retarget);
    idle_inputs();
    set_instr(ADI, 16'h0104, 3'd2, 3'd1, 3'd2);
    branch_valid_i = 1; branch_pc_i = retarget ? 16'h4000 : tgt;
    cycle();
    n_checks++;
    if (opcode_valid_o !== 1'b0) $display("FAIL %s_branch_slot: got %0b want 0", nm,
                                          opcode_valid_o);
    else n_pass++;
    if (retarget) begin
      idle_inputs();
      set_instr(ADD, 16'h0106, 3'd1, 3'd1, 3'd1);
      branch_valid_i = 1; branch_pc_i = tgt;
      cycle();
      n_checks++;
      if (opcode_valid_o !== 1'b0) $display("FAIL %s_retarget_slot: got %0b want 0", nm,
                                            opcode_valid_o);
      else n_pass++;
    end
    idle_inputs();
    set_instr(NDZ, 16'h0110, 3'd1, 3'd3, 3'd5);
    ex_rd_idx_i = 3; ex_val_i = 16'h00DC; mem_rd_idx_i = 5; mem_val_i = 16'h00AB;
    wb_rd_idx_i = 4; wb_val_i = 16'h00FF;
    cycle();
    n_checks++;
    if (opcode_valid_o !== 1'b0) $display("FAIL %s_wrong_path: got %0b want 0", nm,
                                          opcode_valid_o);
    else n_pass++;
    if (retarget) begin
      idle_inputs();
      set_instr(ADZ, 16'h4000, 3'd2, 3'd4, 3'd6);
      cycle();
      n_checks++;
      if (opcode_valid_o !== 1'b0) $display("FAIL %s_old_target: got %0b want 0", nm,
                                            opcode_valid_o);
      else n_pass++;
    end
    idle_inputs();
    set_instr(retarget ? ADC : ADZ, tgt, 3'd2, 3'd4, 3'd6);
    cycle();
    n_checks++;
    if ({opcode_valid_o, opcode_pc_o, operand_val_a, operand_val_b} !==
        {1'b1, tgt, 16'h00FF, 16'h7777})
      $display("FAIL %s_target: got v=%0b pc=%h a=%h b=%h want 1 %h 00ff 7777", nm,
               opcode_valid_o, opcode_pc_o, operand_val_a, operand_val_b, tgt);
    else n_pass++;
  endtask

  task automatic test_fwd_priority();
    logic [15:0] want [0:3];
    want[0] = 16'h00DC; want[1] = 16'h00AB; want[2] = 16'h00FF; want[3] = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      set_instr(ADD, 16'h0200 + 16'(k), 3'd1, (k == 3) ? 3'd0 : 3'd3, 3'd2);
      ex_val_i = 16'h00DC; mem_val_i = 16'h00AB; wb_val_i = 16'h00FF;
      ex_rd_idx_i = (k == 0 || k == 3) ? 3'd3 : 3'd0;
      mem_rd_idx_i = (k <= 1 || k == 3) ? 3'd3 : 3'd0;
      wb_rd_idx_i = 3;
      cycle();
      n_checks++;
      if (operand_val_a !== want[k] || opcode_valid_o !== 1'b1)
        $display("FAIL fwd_priority%0d: got v=%0b a=%h want 1 %h", k, opcode_valid_o,
                 operand_val_a, want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    set_instr(ADD, 16'h0300, 3'd2, 3'd1, 3'd3);
    load_en_i = 1; ex_rd_idx_i = 3; ex_val_i = 16'h1234;
    #1;
    n_checks++;
    if (mem_stall_o !== 1'b1) $display("FAIL load_use_stall: got %0b want 1", mem_stall_o);
    else n_pass++;
    cycle();
    n_checks++;
    if (opcode_valid_o !== 1'b0) $display("FAIL load_use_bubble: got %0b want 0",
                                          opcode_valid_o);
    else n_pass++;
    load_en_i = 0;
    #1;
    n_checks++;
    if (mem_stall_o !== 1'b0) $display("FAIL no_load_stall: got %0b want 0", mem_stall_o);
    else n_pass++;
    cycle();
    n_checks++;
    if (opcode_valid_o !== 1'b1 || operand_val_b !== 16'h1234)
      $display("FAIL no_load_fwd: got v=%0b b=%h want 1 1234", opcode_valid_o, operand_val_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid_squash();
    idle_inputs();
    set_instr(ADD, 16'h0104, 3'd1, 3'd1, 3'd1);
    branch_valid_i = 1; branch_pc_i = 16'h4000;
    cycle();
    idle_inputs();
    set_instr(ADD, 16'h0106, 3'd1, 3'd1, 3'd1);
    #2;
    rst_i = 0;
    m_reset();
    #1;
    n_checks++;
    if ({opcode_valid_o, opcode_pc_o, opcode_instr_o, one_hot_o, operand_val_a,
         operand_val_b, exec_rd_idx_o, imm_val_o} !== '0)
      $display("FAIL reset_mid_squash: got v=%0b pc=%h a=%h want all zero",
               opcode_valid_o, opcode_pc_o, operand_val_a);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1;
    idle_inputs();
    set_instr(ADC, 16'h0102, 3'd4, 3'd0, 3'd0);
    cycle();
    n_checks++;
    if (opcode_valid_o !== 1'b1 || opcode_pc_o !== 16'h0102)
      $display("FAIL after_reset_accept: got v=%0b pc=%h want 1 0102", opcode_valid_o,
               opcode_pc_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] pcs [0:3];
    int bad = 0;
    pcs[0] = 16'h4000; pcs[1] = 16'h9000; pcs[2] = 16'h0500; pcs[3] = 16'h0A0A;
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      set_instr($urandom_range(0, 14), pcs[$urandom_range(0, 3)], 3'($urandom),
                3'($urandom), 3'($urandom));
      opcode_valid_i = ($urandom_range(0, 7) != 0);
      load_en_i = ($urandom_range(0, 3) == 0);
      branch_valid_i = ($urandom_range(0, 9) == 0);
      branch_pc_i = pcs[$urandom_range(0, 3)];
      ex_rd_idx_i = 3'($urandom); ex_val_i = 16'($urandom);
      mem_rd_idx_i = 3'($urandom); mem_val_i = 16'($urandom);
      wb_rd_idx_i = 3'($urandom); wb_val_i = 16'($urandom);
      #1;
      n_checks++;
      if (mem_stall_o !== m_stall()) begin
        $display("FAIL rand_stall%0d: got %0b want %0b", n, mem_stall_o, m_stall());
        bad++;
      end else n_pass++;
      cycle();
      n_checks++;
      if (opcode_valid_o !== e_valid ||
          (e_valid && {opcode_pc_o, opcode_instr_o, one_hot_o, operand_val_a, operand_val_b,
                       exec_rd_idx_o, imm_val_o} !==
                      {e_pc, e_instr, e_oh, e_a, e_b, e_rd, e_imm})) begin
        if (bad < 10)
          $display("FAIL rand_slot%0d: got v=%0b pc=%h a=%h b=%h want %0b %h %h %h", n,
                   opcode_valid_o, opcode_pc_o, operand_val_a, operand_val_b,
                   e_valid, e_pc, e_a, e_b);
        bad++;
      end else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (dut.gpr[i] !== m_gpr[i])
        $display("FAIL rand_gpr%0d: got %h want %h", i, dut.gpr[i], m_gpr[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    load_gprs();
    test_wb_bypass();
    test_branch("squash", 16'h4000, 1'b0);
    test_branch("retarget", 16'h9000, 1'b1);
    test_fwd_priority();
    test_load_use();
    test_reset_mid_squash();
    load_gprs();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
